// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a show-ahead FIFO one word at a time onto a UART line.
// Ports: clk, res_n, enable, fifo_empty/fifo_rdata in; fifo_shift_out, tx, busy out.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_shift_out,
  output logic             tx,
  output logic             busy
);

  localparam int CW = $clog2(2 * CLKS_PER_BIT);
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] BIT_END =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_END =
    CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT =
    BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             pop;

  // Pop is masked by res_n so no strobe leaks out while held in reset.
  assign pop = enable & ~fifo_empty &
               (state_q == IDLE) & res_n;

  assign fifo_shift_out = pop;
  assign tx             = tx_q;
  assign busy           = (state_q != IDLE);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pop) begin
          sh_d    = fifo_rdata;
          par_d   = ^fifo_rdata;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = sh_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            sh_d  = sh_q >> 1;
            tx_d  = sh_d[0];
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == STOP_END) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: checks fifo_uart_tx frames against an expected bit list.
// Three instances cover parity off/on and one/two stop bits.
module tb_fifo_uart_tx;

  localparam int C = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  logic [2:0] en_w = '0;
  logic [2:0] emp_w;
  logic [2:0] so_w, tx_w, busy_w;
  logic so0, so1, so2, tx0, tx1, tx2;
  logic bz0, bz1, bz2;
  logic [7:0] rd_w [3];
  logic [7:0] mem [3][64];
  int rp [3] = '{0, 0, 0};
  int wp [3] = '{0, 0, 0};
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int waits, pc, prev, r;
  logic [7:0] dec, w1, w2, w3, w4;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  assign so_w   = {so2, so1, so0};
  assign tx_w   = {tx2, tx1, tx0};
  assign busy_w = {bz2, bz1, bz0};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 3; d++)
      if (so_w[d]) rp[d] <= rp[d] + 1;
  end

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      emp_w[d] = (rp[d] == wp[d]);
      rd_w[d]  = mem[d][rp[d] % 64];
    end
  end

  fifo_uart_tx #(
    .WIDTH(8), .CLKS_PER_BIT(C),
    .PARITY_EN(0), .STOP_BITS(1)
  ) u0 (
    .clk(clk), .res_n(res_n),
    .enable(en_w[0]), .fifo_empty(emp_w[0]),
    .fifo_rdata(rd_w[0]),
    .fifo_shift_out(so0), .tx(tx0), .busy(bz0)
  );

  fifo_uart_tx #(
    .WIDTH(8), .CLKS_PER_BIT(C),
    .PARITY_EN(1), .STOP_BITS(1)
  ) u1 (
    .clk(clk), .res_n(res_n),
    .enable(en_w[1]), .fifo_empty(emp_w[1]),
    .fifo_rdata(rd_w[1]),
    .fifo_shift_out(so1), .tx(tx1), .busy(bz1)
  );

  fifo_uart_tx #(
    .WIDTH(8), .CLKS_PER_BIT(C),
    .PARITY_EN(1), .STOP_BITS(2)
  ) u2 (
    .clk(clk), .res_n(res_n),
    .enable(en_w[2]), .fifo_empty(emp_w[2]),
    .fifo_rdata(rd_w[2]),
    .fifo_shift_out(so2), .tx(tx2), .busy(bz2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input logic [7:0] w);
    mem[d][wp[d] % 64] = w;
    wp[d]++;
  endtask

  // Waits for a pop on instance d, then checks every cycle of the frame
  // against the bit list built from the frame format.
  task automatic run_frame(input int d,
                           input logic [7:0] w,
                           input int par,
                           input int stp,
                           input string tag,
                           output int wt,
                           output int pcyc,
                           output logic [7:0] dw);
    int f;
    logic eb [16];
    logic smp [64];
    f = (1 + 8 + par + stp) * C;
    for (int i = 0; i < 16; i++) eb[i] = 1'b1;
    eb[0] = 1'b0;
    for (int i = 0; i < 8; i++) eb[1 + i] = w[i];
    if (par != 0) eb[9] = ^w;
    wt = 0;
    dw = '0;
    #1;
    while (!so_w[d] && wt < 400) begin
      @(negedge clk);
      #1;
      wt++;
    end
    if (!so_w[d]) begin
      chk({tag, " pop timeout"}, 32'(so_w[d]), 1);
      pcyc = cyc;
      return;
    end
    pcyc = cyc;
    for (int k = 0; k < f; k++) begin
      @(posedge clk);
      #1;
      smp[k] = tx_w[d];
      chk($sformatf("%s cyc%0d", tag, k),
          {tx_w[d], busy_w[d], so_w[d]},
          {eb[k / C], 1'b1, 1'b0});
    end
    @(posedge clk);
    #1;
    chk({tag, " idle"}, {tx_w[d], busy_w[d]}, 2'b10);
    for (int i = 0; i < 8; i++)
      dw[i] = smp[C * (1 + i) + C / 2];
    chk({tag, " word"}, dw, w);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    push(0, 8'hA5);
    en_w[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("reset", {tx_w[0], busy_w[0], so_w[0]}, 3'b100);
    end
    res_n = 1'b1;
    run_frame(0, 8'hA5, 0, 1, "single", waits, pc, dec);
    chk("single popwait", waits, 0);
    chk("single pops", rp[0], 1);
    en_w[0] = 1'b0;

    push(1, 8'h07);
    push(1, 8'hA5);
    en_w[1] = 1'b1;
    run_frame(1, 8'h07, 1, 1, "par07", waits, pc, dec);
    run_frame(1, 8'hA5, 1, 1, "parA5", waits, pc, dec);
    en_w[1] = 1'b0;
    push(2, 8'hA5);
    en_w[2] = 1'b1;
    run_frame(2, 8'hA5, 1, 2, "stop2", waits, pc, dec);
    en_w[2] = 1'b0;
    chk("parity pops", rp[1] + rp[2], 3);

    @(negedge clk);
    for (int i = 0; i < 2 ** DEPTH; i++) begin
      exp_q.push_back(8'($urandom));
      push(0, exp_q[i]);
    end
    en_w[0] = 1'b1;
    prev = 0;
    for (int i = 0; i < 2 ** DEPTH; i++) begin
      run_frame(0, exp_q[i], 0, 1,
                $sformatf("b2b%0d", i), waits, pc, dec);
      if (i > 0) chk("b2b period", pc - prev, 41);
      prev = pc;
    end
    chk("b2b empty", emp_w[0], 1);
    r = rp[0];
    repeat (50) @(negedge clk);
    chk("b2b nopop", rp[0], r);
    chk("b2b pops", rp[0], 1 + 2 ** DEPTH);

    en_w[0] = 1'b0;
    @(negedge clk);
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    push(0, w1);
    push(0, w2);
    en_w[0] = 1'b1;
    fork
      run_frame(0, w1, 0, 1, "engate", waits, pc, dec);
      begin
        @(posedge clk);
        repeat (10) @(posedge clk);
        #2 en_w[0] = 1'b0;
      end
    join
    repeat (20) begin
      @(negedge clk);
      chk("engate idle", {tx_w[0], busy_w[0], so_w[0]}, 3'b100);
    end
    chk("engate pops", rp[0], 2 + 2 ** DEPTH);
    en_w[0] = 1'b1;
    run_frame(0, w2, 0, 1, "reen", waits, pc, dec);
    chk("reen popwait", waits, 0);

    @(negedge clk);
    w3 = 8'($urandom);
    w4 = 8'($urandom);
    push(0, w3);
    push(0, w4);
    #1;
    chk("midrst pop", so_w[0], 1);
    repeat (13) @(posedge clk);
    #2 res_n = 1'b0;
    #1;
    chk("midrst async", {tx_w[0], busy_w[0], so_w[0]}, 3'b100);
    repeat (3) @(negedge clk);
    res_n = 1'b1;
    run_frame(0, w4, 0, 1, "afterrst", waits, pc, dec);
    chk("afterrst popwait", waits, 0);
    chk("final pops", rp[0], 5 + 2 ** DEPTH);
    chk("final empty", emp_w[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
